// File: rtl/winner_scan_fsm.sv
// Post-poll winner scan: snapshots all tallies, walks them through an
// external magnitude comparator and reports winner, tie and no-vote status.
module winner_scan_fsm #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_CAND*CNT_W-1:0] count_flat,
    output logic [CNT_W-1:0]        cmp_a,
    output logic [CNT_W-1:0]        cmp_b,
    output logic                    cmp_enable,
    input  logic                    cmp_eq,
    input  logic                    cmp_gt,
    input  logic                    cmp_lt,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        winner_idx,
    output logic [CNT_W-1:0]        winner_count,
    output logic                    tie,
    output logic                    no_votes,
    output logic                    cmp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CAND - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_CAND];
    logic [CNT_W-1:0] cnt_d [N_CAND];
    logic [CNT_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             run_tie_q, run_tie_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [CNT_W-1:0] cmp_a_q, cmp_a_d;
    logic [CNT_W-1:0] cmp_b_q, cmp_b_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_tie_q, win_tie_d;
    logic             nov_q, nov_d;

    logic [CNT_W-1:0] step_max;
    logic [IDX_W-1:0] step_idx;
    logic             step_tie;
    logic             step_err;
    logic             step_nov;
    logic [IDX_W-1:0] nxt_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        idx_d     = idx_q;
        run_tie_d = run_tie_q;
        err_d     = err_q;
        i_d       = i_q;
        cmp_a_d   = cmp_a_q;
        cmp_b_d   = cmp_b_q;
        win_idx_d = win_idx_q;
        win_cnt_d = win_cnt_q;
        win_tie_d = win_tie_q;
        nov_d     = nov_q;

        // Illegal flag combinations fall through as "less than".
        step_max = max_q;
        step_idx = idx_q;
        step_tie = run_tie_q;
        step_err = err_q;
        case ({cmp_eq, cmp_gt, cmp_lt})
            3'b010: begin
                step_max = cnt_q[i_q];
                step_idx = i_q;
                step_tie = 1'b0;
            end
            3'b100:  step_tie = 1'b1;
            3'b001:  ;
            default: step_err = 1'b1;
        endcase
        step_nov = (step_max == '0);
        nxt_i    = i_q + IDX_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < N_CAND; k++) begin
                        cnt_d[k] = count_flat[k*CNT_W +: CNT_W];
                    end
                    max_d     = count_flat[0 +: CNT_W];
                    idx_d     = '0;
                    run_tie_d = 1'b0;
                    err_d     = 1'b0;
                    i_d       = IDX_W'(1);
                    cmp_a_d   = count_flat[CNT_W +: CNT_W];
                    cmp_b_d   = count_flat[0 +: CNT_W];
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                max_d     = step_max;
                idx_d     = step_idx;
                run_tie_d = step_tie;
                err_d     = step_err;
                if (i_q == LAST) begin
                    win_cnt_d = step_max;
                    nov_d     = step_nov;
                    win_idx_d = step_nov ? '0 : step_idx;
                    win_tie_d = step_tie && !step_nov;
                    state_d   = S_DONE;
                end else begin
                    i_d     = nxt_i;
                    cmp_a_d = cnt_q[nxt_i];
                    cmp_b_d = step_max;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N_CAND; k++) begin
                cnt_q[k] <= '0;
            end
            max_q     <= '0;
            idx_q     <= '0;
            run_tie_q <= 1'b0;
            err_q     <= 1'b0;
            i_q       <= '0;
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
            win_idx_q <= '0;
            win_cnt_q <= '0;
            win_tie_q <= 1'b0;
            nov_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            run_tie_q <= run_tie_d;
            err_q     <= err_d;
            i_q       <= i_d;
            cmp_a_q   <= cmp_a_d;
            cmp_b_q   <= cmp_b_d;
            win_idx_q <= win_idx_d;
            win_cnt_q <= win_cnt_d;
            win_tie_q <= win_tie_d;
            nov_q     <= nov_d;
        end
    end

    assign cmp_a        = cmp_a_q;
    assign cmp_b        = cmp_b_q;
    assign cmp_enable   = (state_q == S_COMPARE);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign winner_idx   = win_idx_q;
    assign winner_count = win_cnt_q;
    assign tie          = win_tie_q;
    assign no_votes     = nov_q;
    assign cmp_err      = err_q;

endmodule

// File: tb/tb_winner_scan_fsm.sv
// Scoreboard bench for winner_scan_fsm with a behavioural 4-bit comparator
// and an optional fault that drives an illegal flag pair on step 2.
module tb_winner_scan_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] count_flat;
    logic [3:0]  cmp_a, cmp_b;
    logic        cmp_enable;
    logic        cmp_eq, cmp_gt, cmp_lt;
    logic        busy, done;
    logic [1:0]  winner_idx;
    logic [3:0]  winner_count;
    logic        tie, no_votes, cmp_err;

    typedef struct {
        int idx;
        int cnt;
        int tie;
        int nov;
        int err;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   step  = 0;
    logic fault_en = 1'b0;

    always #5 clk = ~clk;

    winner_scan_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .count_flat  (count_flat),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_enable  (cmp_enable),
        .cmp_eq      (cmp_eq),
        .cmp_gt      (cmp_gt),
        .cmp_lt      (cmp_lt),
        .busy        (busy),
        .done        (done),
        .winner_idx  (winner_idx),
        .winner_count(winner_count),
        .tie         (tie),
        .no_votes    (no_votes),
        .cmp_err     (cmp_err)
    );

    always_comb begin
        cmp_eq = 1'b0;
        cmp_gt = 1'b0;
        cmp_lt = 1'b0;
        if (cmp_enable) begin
            cmp_eq = (cmp_a == cmp_b);
            cmp_gt = (cmp_a > cmp_b);
            cmp_lt = (cmp_a < cmp_b);
            if (fault_en && step == 2) begin
                cmp_eq = 1'b1;
                cmp_gt = 1'b1;
                cmp_lt = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || !busy) step <= 1;
        else if (cmp_enable) step <= step + 1;
    end

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("winner_idx", int'(winner_idx), e.idx);
                chk("winner_count", int'(winner_count), e.cnt);
                chk("tie", int'(tie), e.tie);
                chk("no_votes", int'(no_votes), e.nov);
                chk("cmp_err", int'(cmp_err), e.err);
                chk("busy_at_done", int'(busy), 1);
            end
        end
    end

    function automatic int all_outs();
        return int'({cmp_a, cmp_b, cmp_enable, busy, done, winner_idx,
                     winner_count, tie, no_votes, cmp_err});
    endfunction

    task automatic launch(input int c0, c1, c2, c3,
                          input int idx, cnt, t, nv, err);
        exp_t e;
        @(negedge clk);
        count_flat = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
        start      = 1'b1;
        e.idx = idx; e.cnt = cnt; e.tie = t;
        e.nov = nv;  e.err = err; e.cyc = cyc + 4;
        sb.push_back(e);
        @(negedge clk);
        start      = 1'b0;
        count_flat = 16'hA5C3;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({name, "_drained"}, sb.size(), 0);
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        count_flat = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;

        launch(3, 7, 2, 5, 1, 7, 0, 0, 0);
        drain("t1");
        launch(6, 2, 6, 1, 0, 6, 1, 0, 0);
        drain("t2");
        launch(4, 4, 9, 0, 2, 9, 0, 0, 0);
        drain("t3");
        launch(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drain("t4");
        launch(15, 15, 15, 15, 0, 15, 1, 0, 0);
        drain("t4b");

        // Abort in the second compare cycle; no done may follow.
        @(negedge clk);
        count_flat = {4'd8, 4'd6, 4'd4, 4'd2};
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t5_in_compare", int'(cmp_enable), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Second start while busy must be ignored.
        launch(1, 2, 3, 4, 3, 4, 0, 0, 0);
        start      = 1'b1;
        count_flat = 16'h9999;
        @(negedge clk);
        start = 1'b0;
        drain("t5b");
        repeat (6) @(negedge clk);

        fault_en = 1'b1;
        launch(5, 3, 8, 2, 0, 5, 0, 0, 1);
        drain("t6");
        fault_en = 1'b0;
        launch(5, 3, 8, 2, 2, 8, 0, 0, 0);
        drain("t6b");

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
